// File: rtl/ps2_hit_encoder_if.sv
// ps2_hit_encoder_if
//   Bundles the PS/2 pins and the decoded game-control outputs of ps2_hit_encoder.
//   master : the encoder (consumes the PS/2 pins, drives the decoded outputs)
//   slave  : the board / game side (drives the PS/2 pins, samples the outputs)
//   Signals:
//     ps2_clk, ps2_dat : raw PS/2 pins, asynchronous, idle high
//     hit[2:0]         : hole code 1-5 for one cycle on a new key press, else 0
//     start_pulse      : one-cycle pulse on a new space-bar press
//     frame_error      : one-cycle pulse on parity, stop-bit or timeout error
//     rx_byte[7:0]     : last correctly received byte
//     rx_strobe        : one-cycle pulse when rx_byte updates
interface ps2_hit_encoder_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [2:0] hit;
    logic       start_pulse;
    logic       frame_error;
    logic [7:0] rx_byte;
    logic       rx_strobe;

    modport master (
        input  ps2_clk,
        input  ps2_dat,
        output hit,
        output start_pulse,
        output frame_error,
        output rx_byte,
        output rx_strobe
    );

    modport slave (
        output ps2_clk,
        output ps2_dat,
        input  hit,
        input  start_pulse,
        input  frame_error,
        input  rx_byte,
        input  rx_strobe
    );
endinterface

// File: rtl/ps2_hit_encoder.sv
// ps2_hit_encoder
//   Receives 11-bit PS/2 keyboard frames (start, 8 data LSB first, odd parity, stop) and
//   turns keys 1-5 into one-cycle hole codes and the space bar into a start pulse.
//   Break (F0) and extended (E0) prefixes are tracked; typematic repeats are suppressed.
//   Ports:
//     clock  : system clock
//     reset  : asynchronous, active-high reset
//     io_bus : ps2_hit_encoder_if.master (PS/2 pins in, decoded outputs out)
module ps2_hit_encoder #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                      clock,
    input  logic                      reset,
    ps2_hit_encoder_if.master         io_bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    // Code 6 is the space bar; it shares the pressed/repeat logic with the hole keys.
    localparam logic [2:0] CodeSpace = 3'd6;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;
    state_e          r_state, w_state_next;
    logic [7:0]      r_shift, w_shift_next;
    logic [2:0]      r_bit_cnt, w_bit_cnt_next;
    logic            r_parity, w_parity_next;
    logic [CntW-1:0] r_tcnt, w_tcnt_next;
    logic            r_ext, w_ext_next;
    logic            r_brk, w_brk_next;
    logic [7:0]      r_pressed, w_pressed_next;
    logic [2:0]      r_hit, w_hit_next;
    logic            r_start, w_start_next;
    logic            r_err;
    logic [7:0]      r_rx_byte;
    logic            r_rx_strobe;

    logic            w_edge;
    logic            w_timeout;
    logic            w_frame_good;
    logic            w_frame_bad;
    logic [2:0]      w_code;

    assign w_edge    = r_clk_prev & ~r_clk_s2;
    assign w_timeout = (r_state != StIdle) && (r_tcnt == CntMax);

    // Receiver next-state
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        w_frame_good   = 1'b0;
        w_frame_bad    = 1'b0;
        if (w_timeout) begin
            w_state_next = StIdle;
            w_frame_bad  = 1'b1;
        end else if (w_edge) begin
            unique case (r_state)
                StIdle: begin
                    // A high start bit is line noise: ignore it silently.
                    if (!r_dat_s2) begin
                        w_state_next   = StData;
                        w_bit_cnt_next = 3'd0;
                    end
                end
                StData: begin
                    w_shift_next   = {r_dat_s2, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = StParity;
                    end
                end
                StParity: begin
                    w_parity_next = r_dat_s2;
                    w_state_next  = StStop;
                end
                StStop: begin
                    if (r_dat_s2 && (^{r_shift, r_parity})) begin
                        w_frame_good = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                    w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Inactivity counter, saturating
    always_comb begin
        w_tcnt_next = r_tcnt;
        if (w_edge) begin
            w_tcnt_next = '0;
        end else if (r_state != StIdle && r_tcnt != CntMax) begin
            w_tcnt_next = r_tcnt + CntW'(1);
        end
    end

    always_comb begin
        unique case (r_shift)
            8'h16:   w_code = 3'd1;
            8'h1E:   w_code = 3'd2;
            8'h26:   w_code = 3'd3;
            8'h25:   w_code = 3'd4;
            8'h2E:   w_code = 3'd5;
            8'h29:   w_code = CodeSpace;
            default: w_code = 3'd0;
        endcase
    end

    // Byte decode: prefixes, press/release tracking, repeat suppression
    always_comb begin
        w_ext_next     = r_ext;
        w_brk_next     = r_brk;
        w_pressed_next = r_pressed;
        w_hit_next     = 3'd0;
        w_start_next   = 1'b0;
        if (w_frame_bad) begin
            w_ext_next = 1'b0;
            w_brk_next = 1'b0;
        end else if (w_frame_good) begin
            if (r_shift == 8'hE0) begin
                w_ext_next = 1'b1;
            end else if (r_shift == 8'hF0) begin
                w_brk_next = 1'b1;
            end else begin
                w_ext_next = 1'b0;
                w_brk_next = 1'b0;
                // Extended keys share scan codes with the hole keys; they must not fire.
                if (!r_ext && w_code != 3'd0) begin
                    if (r_brk) begin
                        w_pressed_next[w_code] = 1'b0;
                    end else if (!r_pressed[w_code]) begin
                        w_pressed_next[w_code] = 1'b1;
                        if (w_code == CodeSpace) begin
                            w_start_next = 1'b1;
                        end else begin
                            w_hit_next = w_code;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_state     <= StIdle;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_parity    <= 1'b0;
            r_tcnt      <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_pressed   <= 8'h00;
            r_hit       <= 3'd0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_rx_strobe <= 1'b0;
        end else begin
            r_clk_s1    <= io_bus.ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_clk_prev  <= r_clk_s2;
            r_dat_s1    <= io_bus.ps2_dat;
            r_dat_s2    <= r_dat_s1;
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_parity    <= w_parity_next;
            r_tcnt      <= w_tcnt_next;
            r_ext       <= w_ext_next;
            r_brk       <= w_brk_next;
            r_pressed   <= w_pressed_next;
            r_hit       <= w_hit_next;
            r_start     <= w_start_next;
            r_err       <= w_frame_bad;
            r_rx_strobe <= w_frame_good;
            if (w_frame_good) begin
                r_rx_byte <= r_shift;
            end
        end
    end

    assign io_bus.hit         = r_hit;
    assign io_bus.start_pulse = r_start;
    assign io_bus.frame_error = r_err;
    assign io_bus.rx_byte     = r_rx_byte;
    assign io_bus.rx_strobe   = r_rx_strobe;

endmodule

// File: doc/ps2_hit_encoder.md
# ps2_hit_encoder

Receives PS/2 keyboard frames and turns them into the game's control inputs: a one-cycle hit code (1–5 for mole holes, 0 for none) and a start pulse. It sits between the board's PS/2 pins and the game datapath, which samples `hit` and `start_pulse` every clock. The block includes an 11-bit frame receiver with parity and timeout checking, plus break/extended-prefix tracking and typematic-repeat suppression.

## Interface
- `TIMEOUT_CYCLES`, default 5000: clock cycles without a PS/2 falling edge before a partial frame is abandoned (100 µs at 50 MHz).
- `clock` input, 1 bit: system clock, 50 MHz.
- `reset` input, 1 bit: reset, asynchronous, active-high. Clock is `clock`.
- `ps2_clk` input, 1 bit: raw PS/2 clock pin, asynchronous, idle high.
- `ps2_dat` input, 1 bit: raw PS/2 data pin, asynchronous, idle high.
- `hit` output, 3 bits: hole code 1–5 for exactly one cycle on a new key press; 0 otherwise.
- `start_pulse` output, 1 bit: one-cycle pulse on a new space-bar press.
- `frame_error` output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.
- `rx_byte` output, 8 bits: last correctly received byte; holds its value between frames.
- `rx_strobe` output, 1 bit: one-cycle pulse when `rx_byte` updates.

## Operation
- **Synchronisers.** `ps2_clk` and `ps2_dat` each pass through 2 flip-flops, reset to 1. A third register on the clock path gives falling-edge detection: previous synced = 1, current synced = 0. Data is sampled from synced `ps2_dat` in the edge cycle.
- **Receiver FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on an edge, data 0 → DATA and bit count cleared. Data 1 is a bogus start bit: stay in IDLE, no error.
  - DATA: shift data in LSB first, one bit per edge. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: on an edge, if data = 1 and the parity of the 9 bits (data + parity) is odd, the frame is good. Otherwise pulse `frame_error`. Either way → IDLE.
- **Timeout.** The counter clears on every edge and increments in any non-IDLE state. When it reaches `TIMEOUT_CYCLES`: → IDLE and pulse `frame_error`.
- **Good frame.** Load `rx_byte` and pulse `rx_strobe`, then decode the byte:
  - 0xE0: set the ext flag.
  - 0xF0: set the brk flag.
  - Any other byte with ext set: ignore it and clear both flags.
  - Otherwise, key 1/2/3/4/5 (scan codes 0x16/0x1E/0x26/0x25/0x2E) maps to index k = 1–5:
    - brk = 0 and `pressed[k]` = 0: set `pressed[k]` and issue `hit` = k.
    - brk = 0 and `pressed[k]` = 1: typematic repeat, no output.
    - brk = 1: clear `pressed[k]`.
  - Space (0x29) follows the same rules with its own pressed bit, issuing `start_pulse`.
  - Other codes produce no output.
  - Both flags clear after any non-prefix byte.
- **Frame errors** clear ext and brk; the `pressed` state is kept.
- **Reset** (asynchronous, any time, including mid-frame): FSM to IDLE; shift register, bit count, timeout counter, flags and `pressed` all cleared; synchronisers set to 1.

## Timing
- Reset values: `hit` = 0, `start_pulse` = 0, `frame_error` = 0, `rx_byte` = 0x00, `rx_strobe` = 0.
- Edge detection lags a pin edge by 3 clocks.
- Let N be the cycle in which the stop-bit edge is detected. In cycle N+1:
  - `rx_strobe` and `rx_byte` update.
  - `hit` / `start_pulse` assert if the byte decodes to a press.
  - `frame_error` asserts if the frame is bad.
- All pulses last exactly one cycle. `hit` and `start_pulse` never assert in the same cycle, because each comes from a distinct frame.
- A timeout error pulses in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and does not wrap.

## Test plan
- **Single press.** Frame 0x16 with parity 0, stop 1 → `rx_byte` = 0x16, `hit` = 3'd1 for one cycle, 1 cycle after the stop edge; `frame_error` stays 0.
- **Repeat and release.** Frames 0x1E, 0x1E, F0, 0x1E, 0x1E (0x1E parity 1, F0 parity 1) → `hit` = 2 after the 1st and 5th frames only; no output for the 2nd–4th.
- **Extended and start.** Frames E0, 0x16 → no `hit`. Then 0x29 (parity 0) → `start_pulse` = 1 for one cycle, `hit` = 0.
- **Errors.** 0x16 with parity 1 → `frame_error` pulse, no `hit`, `rx_strobe` = 0. 0x16 with stop bit 0 → `frame_error`. Next good 0x16 → `hit` = 1.
- **Timeout.** Start bit plus 4 data bits, then `ps2_clk` held high for `TIMEOUT_CYCLES` → `frame_error` pulse, FSM back in IDLE. Then a full 0x26 frame → `hit` = 3.
- **Reset mid-frame.** `reset` asserted after 5 bits of 0x2E → all outputs 0 immediately. After release, `pressed` is cleared: frame 0x2E → `hit` = 5, even if 0x2E was held before the reset.
